mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit beside the register file.
- Consumes the two operands read from the register file (qa, qb) for MULT/MULTU/DIV/DIVU and produces results into internal HI/LO registers.
- Asserts busy so the control unit can stall the PC. The datapath reads HI/LO for MFHI/MFLO and writes them for MTHI/MTLO.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk    input   1      clock, rising edge
- clrn   input   1      asynchronous active-low reset
- start  input   1      launch an operation; sampled only in IDLE
- op     input   2      00 multu, 01 mult, 10 divu, 11 div
- a      input   WIDTH  operand A / dividend (register file qa)
- b      input   WIDTH  operand B / divisor (register file qb)
- hi_we  input   1      MTHI write enable
- lo_we  input   1      MTLO write enable
- wdata  input   WIDTH  MTHI/MTLO data
- busy   output  1      operation in progress; the stall request
- done   output  1      one-cycle pulse; HI/LO hold the new result
- dz     output  1      divide-by-zero flag; valid with done, held until next start
- hi     output  WIDTH  HI register
- lo     output  WIDTH  LO register

Behaviour:
- Reset (clrn=0, asynchronous, may occur mid-operation):
  - State IDLE, busy=0, done=0, dz=0, hi=0, lo=0.
  - Iteration counter and working registers cleared.
  - An in-flight operation is discarded.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - busy=0.
  - At an edge with start=1: latch a, b and op; load absolute values for signed ops; record result signs; clear counter; go to RUN.
- RUN:
  - busy=1.
  - One radix-2 step per edge: shift-add for multiply, restoring shift-subtract for divide.
  - After WIDTH steps go to FIX.
- FIX:
  - busy=1.
  - At the exit edge, apply sign correction and write HI/LO, pulse done=1, return to IDLE.
  - busy and done are registered outputs.
- Timing: start sampled at edge T -> busy=1 during cycles T..T+32 -> at edge T+33 HI/LO updated, done=1, busy=0. Latency is 33 cycles.
- Back-to-back: start in the done cycle is accepted.
- start while busy is ignored; no queueing.
- Multiply results: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
  - mult is signed two's complement; the product is negated when operand signs differ.
- Divide results: LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0. No flag.
- Divide by zero (b==0, div or divu):
  - LO=all ones, HI=a as latched, dz=1.
  - Same 33-cycle latency.
- dz is cleared at the next accepted start; it is 0 for multiplies.
- MTHI/MTLO: at an edge in IDLE, hi_we writes wdata to HI and lo_we writes wdata to LO. Both may fire in one edge.
  - Writes are ignored in RUN and FIX.
  - If a write coincides with an accepted start, the write is applied and later overwritten by the result.
- hi/lo are stable between operations; they change only on done, MT writes, or reset.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> done one cycle 33 cycles after start, hi=0xFFFFFFFE, lo=0x00000001, busy high exactly 33 cycles.
- mult a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then, from the done cycle, div a=-7 b=2 back-to-back -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7 b=0 -> lo=0xFFFFFFFF, hi=0x00000007, dz=1. Next multu 2*3 -> dz=0, lo=6, hi=0.
- div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
- Start divu 100/7 and re-pulse start with different operands at cycle 5 -> ignored; result lo=14, hi=2. lo_we with wdata=0x1234 during busy -> ignored. lo_we after done -> lo=0x1234.
- Start mult, then assert clrn=0 at cycle 10 -> busy, done, hi and lo go to 0 immediately with no clock edge. After release, no done pulse appears.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with HI/LO result registers
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p, p_step, prod;
    logic [WIDTH-1:0]   m, a_l, abs_a, abs_b, q_fix, r_fix;
    logic [WIDTH:0]     sum, sh, diff;
    logic               is_div, neg_q, neg_r, zdiv;

    // p holds {acc, multiplier} for multiply and {remainder, quotient} for divide; m is the multiplicand or divisor magnitude
    always_comb begin
        abs_a  = (op[0] && a[WIDTH-1]) ? -a : a;
        abs_b  = (op[0] && b[WIDTH-1]) ? -b : b;
        sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        sh     = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff   = sh - {1'b0, m};
        p_step = !is_div ? {sum, p[WIDTH-1:1]} :
                 diff[WIDTH] ? {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0} :
                 {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        prod   = neg_q ? -p : p;
        zdiv   = (m == '0);
        q_fix  = zdiv ? '1 : neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        r_fix  = zdiv ? a_l : neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end

    // control FSM, iteration datapath and HI/LO architectural registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            cnt    <= '0;
            p      <= '0;
            m      <= '0;
            a_l    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        a_l    <= a;
                        is_div <= op[1];
                        m      <= op[1] ? abs_b : abs_a;
                        p      <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
                        neg_q  <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= op[0] && a[WIDTH-1];
                        cnt    <= '0;
                        dz     <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    p   <= p_step;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    hi    <= is_div ? r_fix : prod[2*WIDTH-1:WIDTH];
                    lo    <= is_div ? q_fix : prod[WIDTH-1:0];
                    dz    <= is_div && zdiv;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
    logic        clk, clrn, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, dz;
    logic [31:0] hi, lo;
    int checks = 0;
    int failures = 0;
    int cyc, nb, ndone;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(output int c, output int n);
        c = 0;
        n = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && c < 100) begin
            tick;
            c++;
            if (busy === 1'b1) n++;
        end
    endtask

    initial begin
        clrn = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", dz, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        clrn = 1'b1;
        tick;

        launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_busy_start", busy, 1);
        wait_done(cyc, nb);
        chk("multu_latency", cyc, 33);
        chk("multu_busy_cycles", nb, 33);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        chk("multu_busy_done", busy, 0);
        tick;
        chk("multu_done_pulse", done, 0);
        chk("multu_hi_hold", hi, 32'hFFFFFFFE);

        launch(2'b01, 32'hFFFFFFFD, 32'd5);
        wait_done(cyc, nb);
        chk("mult_latency", cyc, 33);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        launch(2'b11, 32'hFFFFFFF9, 32'd2);
        chk("b2b_busy", busy, 1);
        wait_done(cyc, nb);
        chk("div_latency", cyc, 33);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        launch(2'b10, 32'd7, 32'd0);
        wait_done(cyc, nb);
        chk("dz_latency", cyc, 33);
        chk("dz_lo", lo, 32'hFFFFFFFF);
        chk("dz_hi", hi, 32'd7);
        chk("dz_flag", dz, 1);
        tick;
        chk("dz_held", dz, 1);
        launch(2'b00, 32'd2, 32'd3);
        chk("dz_clear_on_start", dz, 0);
        wait_done(cyc, nb);
        chk("multu23_lo", lo, 32'd6);
        chk("multu23_hi", hi, 32'd0);
        chk("multu23_dz", dz, 0);

        launch(2'b11, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, nb);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'd0);
        chk("ovf_dz", dz, 0);

        launch(2'b10, 32'd100, 32'd7);
        repeat (4) tick;
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
        tick;
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        chk("busy_write_ignored", lo, 32'h80000000);
        wait_done(cyc, nb);
        chk("ignored_start_latency", cyc, 28);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        lo_we = 1'b1; wdata = 32'h1234;
        tick;
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_hi_kept", hi, 32'd2);

        launch(2'b01, 32'h10, 32'h20);
        repeat (9) tick;
        #1;
        clrn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_dz", dz, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        clrn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (done === 1'b1) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        chk("arst_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
